// File: rtl/sni_pkg.sv
// Shared definitions for the SNI hostname front end: FSM encoding, ASCII
// case-folding constants and the folding helper.
package sni_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      FLUSH = 2'd2,
      CLEAR = 2'd3
   } sni_state_e;

   localparam logic [7:0] ASCII_UPPER_A     = 8'h41;
   localparam logic [7:0] ASCII_UPPER_Z     = 8'h5A;
   localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
   localparam logic [7:0] SNI_PAD_BYTE      = 8'h00;
   localparam int         SNI_LEN_W         = 8;

   // Only 'A'..'Z' move; every other byte passes through untouched.
   function automatic logic [7:0] fold_case(input logic [7:0] b);
      logic [7:0] r;
      if ((b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z)) begin
         r = b + ASCII_CASE_OFFSET;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/sni_valid_delay.sv
// Valid shift register: dly[i] is the input valid delayed by i+1 cycles, used
// to line a matcher's hit output up with the pair that produced it.
module sni_valid_delay #(
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   output logic [DEPTH-1:0] dly
);

   generate
      if (DEPTH == 1) begin : g_single
         // Single-stage delay.
         always_ff @(posedge clk) begin
            if (rst) begin
               dly <= 1'b0;
            end else begin
               dly <= valid;
            end
         end
      end else begin : g_shift
         // Multi-stage delay, oldest sample at the top bit.
         always_ff @(posedge clk) begin
            if (rst) begin
               dly <= {DEPTH{1'b0}};
            end else begin
               dly <= {dly[DEPTH-2:0], valid};
            end
         end
      end
   endgenerate

endmodule

// File: rtl/sni_byte_packer.sv
// SNI hostname byte packer: folds case, pairs bytes for a 2-byte/cycle matcher,
// resets the matcher between hostnames and reports one result per hostname.
module sni_byte_packer
   import sni_pkg::*;
#(
   parameter int MATCH_LATENCY = 3,
   parameter int MAX_SNI_BYTES = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_sni_valid,
   input  logic [7:0]           i_sni_data,
   input  logic                 i_sni_last,
   output logic                 o_sni_ready,
   output logic                 o_match_data_valid,
   output logic [15:0]          o_match_data,
   output logic                 o_match_rst,
   input  logic                 i_imaps_matched,
   output logic                 o_result_valid,
   output logic                 o_result_hit,
   output logic [SNI_LEN_W-1:0] o_result_len,
   output logic                 o_result_trunc
);

   localparam logic [SNI_LEN_W-1:0] MAX_LEN  = SNI_LEN_W'(MAX_SNI_BYTES);
   localparam logic [2:0]           LAST_CNT = 3'(MATCH_LATENCY - 32'sd1);

   sni_state_e             state_r;
   logic                   ready_r;
   logic                   done_r;
   logic                   have_hi_r;
   logic [7:0]             hi_r;
   logic [SNI_LEN_W-1:0]   len_r;
   logic                   trunc_r;
   logic                   hit_r;
   logic [2:0]             cnt_r;
   logic                   valid_r;
   logic [15:0]            data_r;
   logic                   res_valid_r;
   logic                   res_hit_r;
   logic [SNI_LEN_W-1:0]   res_len_r;
   logic                   res_trunc_r;
   logic [MATCH_LATENCY-1:0] valid_dly_s;
   logic                   accept_s;
   logic                   fwd_s;
   logic                   hit_now_s;
   logic [7:0]             fold_s;

   sni_valid_delay #(.DEPTH(MATCH_LATENCY)) u_valid_delay (
      .clk   (i_clk),
      .rst   (i_rst),
      .valid (valid_r),
      .dly   (valid_dly_s)
   );

   // Byte acceptance, forwarding limit and matcher-hit alignment.
   always_comb begin
      accept_s  = i_sni_valid & ready_r;
      fwd_s     = accept_s & (len_r != MAX_LEN);
      fold_s    = fold_case(i_sni_data);
      hit_now_s = i_imaps_matched & valid_dly_s[MATCH_LATENCY-1];
   end

   // Packing datapath and hostname FSM.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= IDLE;
         ready_r     <= 1'b1;
         done_r      <= 1'b0;
         have_hi_r   <= 1'b0;
         hi_r        <= 8'h00;
         len_r       <= {SNI_LEN_W{1'b0}};
         trunc_r     <= 1'b0;
         hit_r       <= 1'b0;
         cnt_r       <= 3'd0;
         valid_r     <= 1'b0;
         data_r      <= 16'h0000;
         res_valid_r <= 1'b0;
         res_hit_r   <= 1'b0;
         res_len_r   <= {SNI_LEN_W{1'b0}};
         res_trunc_r <= 1'b0;
      end else begin
         valid_r     <= 1'b0;
         res_valid_r <= 1'b0;
         if (hit_now_s) begin
            hit_r <= 1'b1;
         end
         if (fwd_s) begin
            len_r <= len_r + 8'd1;
            if (have_hi_r) begin
               valid_r   <= 1'b1;
               data_r    <= {hi_r, fold_s};
               have_hi_r <= 1'b0;
            end else if (i_sni_last) begin
               valid_r <= 1'b1;
               data_r  <= {fold_s, SNI_PAD_BYTE};
            end else begin
               hi_r      <= fold_s;
               have_hi_r <= 1'b1;
            end
         end else if (accept_s) begin
            // Past the limit: drop the byte but still flush a pending odd byte.
            trunc_r <= 1'b1;
            if (i_sni_last && have_hi_r) begin
               valid_r   <= 1'b1;
               data_r    <= {hi_r, SNI_PAD_BYTE};
               have_hi_r <= 1'b0;
            end
         end
         if (accept_s && i_sni_last) begin
            ready_r <= 1'b0;
            done_r  <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r <= PACK;
               end
            end
            PACK: begin
               if (done_r) begin
                  state_r <= FLUSH;
                  done_r  <= 1'b0;
                  cnt_r   <= 3'd0;
               end
            end
            FLUSH: begin
               if (cnt_r == LAST_CNT) begin
                  state_r     <= CLEAR;
                  res_valid_r <= 1'b1;
                  res_hit_r   <= hit_r | hit_now_s;
                  res_len_r   <= len_r;
                  res_trunc_r <= trunc_r;
               end else begin
                  cnt_r <= cnt_r + 3'd1;
               end
            end
            CLEAR: begin
               state_r     <= IDLE;
               ready_r     <= 1'b1;
               hit_r       <= 1'b0;
               len_r       <= {SNI_LEN_W{1'b0}};
               trunc_r     <= 1'b0;
               hi_r        <= 8'h00;
               have_hi_r   <= 1'b0;
               data_r      <= 16'h0000;
               cnt_r       <= 3'd0;
               res_hit_r   <= 1'b0;
               res_len_r   <= {SNI_LEN_W{1'b0}};
               res_trunc_r <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign o_sni_ready        = ready_r & ~i_rst;
   assign o_match_data_valid = valid_r;
   assign o_match_data       = data_r;
   assign o_match_rst        = i_rst | (state_r == CLEAR);
   assign o_result_valid     = res_valid_r;
   assign o_result_hit       = res_hit_r;
   assign o_result_len       = res_len_r;
   assign o_result_trunc     = res_trunc_r;

endmodule

// File: tb/tb_sni_byte_packer.sv
// Directed bench for sni_byte_packer with a small matcher stub driven off the
// observed pair stream.
module tb_sni_byte_packer;

   localparam int LAT = 3;

   logic        clk;
   logic        rst;
   logic        sni_valid;
   logic [7:0]  sni_data;
   logic        sni_last;
   logic        sni_ready;
   logic        match_valid;
   logic [15:0] match_data;
   logic        match_rst;
   logic        imaps_matched;
   logic        result_valid;
   logic        result_hit;
   logic [7:0]  result_len;
   logic        result_trunc;

   int total = 0;
   int bad   = 0;

   int          cyc = 0;
   logic [15:0] pairs[$];
   int          runs[$];
   int          last_pair_cyc = 0;
   int          res_count = 0;
   int          res_cyc = 0;
   logic        res_hit = 1'b0;
   logic [7:0]  res_len = 8'h00;
   logic        res_trunc = 1'b0;
   int          stub_pair = -1;
   int          stub_offset = 3;
   int          hit_cyc = -1;
   int          low_run = 0;
   int          mrst_cycles = 0;
   int          stalls = 0;
   logic [7:0]  host_mem [0:511];

   sni_byte_packer #(.MATCH_LATENCY(LAT), .MAX_SNI_BYTES(255)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_sni_valid        (sni_valid),
      .i_sni_data         (sni_data),
      .i_sni_last         (sni_last),
      .o_sni_ready        (sni_ready),
      .o_match_data_valid (match_valid),
      .o_match_data       (match_data),
      .o_match_rst        (match_rst),
      .i_imaps_matched    (imaps_matched),
      .o_result_valid     (result_valid),
      .o_result_hit       (result_hit),
      .o_result_len       (result_len),
      .o_result_trunc     (result_trunc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor and matcher stub, both working on the falling edge.
   initial begin
      imaps_matched = 1'b0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (match_valid === 1'b1) begin
            if (pairs.size() == stub_pair) hit_cyc = cyc + stub_offset;
            pairs.push_back(match_data);
            last_pair_cyc = cyc;
         end
         imaps_matched = (cyc == hit_cyc);
         if (result_valid === 1'b1) begin
            res_count = res_count + 1;
            res_cyc   = cyc;
            res_hit   = result_hit;
            res_len   = result_len;
            res_trunc = result_trunc;
         end
         if (rst === 1'b0 && sni_ready === 1'b0) begin
            low_run = low_run + 1;
         end else if (low_run != 0) begin
            runs.push_back(low_run);
            low_run = 0;
         end
         if (rst === 1'b0 && match_rst === 1'b1) mrst_cycles = mrst_cycles + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic reset_counters();
      pairs.delete();
      runs.delete();
      res_count   = 0;
      low_run     = 0;
      mrst_cycles = 0;
      stalls      = 0;
      stub_pair   = -1;
      stub_offset = 3;
      hit_cyc     = -1;
   endtask

   task automatic send_host(input int n, input int gap, input bit keep_valid, input bit mark_last);
      for (int i = 0; i < n; i++) begin
         int budget;
         budget    = 0;
         sni_valid = 1'b1;
         sni_data  = host_mem[i];
         sni_last  = mark_last && (i == n - 1);
         while (sni_ready !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget = budget + 1;
            stalls = stalls + 1;
         end
         if (budget >= 40) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL send_ready got ready=%b want 1 within 40 cycles", sni_ready);
         end
         @(negedge clk);
         if (gap > 0) begin
            sni_valid = 1'b0;
            sni_last  = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      if (!keep_valid) begin
         sni_valid = 1'b0;
         sni_last  = 1'b0;
      end
   endtask

   task automatic wait_result(input int want);
      int budget;
      budget = 0;
      while (res_count < want && budget < 60) begin
         @(negedge clk);
         budget = budget + 1;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (match_rst !== 1'b1) begin bad++; $display("FAIL rst_match_rst got %b want 1", match_rst); end
      total++; if (sni_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", sni_ready); end
      total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", match_valid); end
      total++; if (match_data !== 16'h0000) begin bad++; $display("FAIL rst_data got %h want 0000", match_data); end
      total++; if (result_valid !== 1'b0 || result_len !== 8'h00) begin bad++; $display("FAIL rst_result got v=%b len=%0d want 0/0", result_valid, result_len); end
      rst = 1'b0;
      #1;
      total++; if (sni_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got %b want 1", sni_ready); end
      total++; if (match_rst !== 1'b0) begin bad++; $display("FAIL rst_match_rst_after got %b want 0", match_rst); end
      @(negedge clk);
   endtask

   task automatic test_imaps();
      logic [15:0] exp_p [0:2];
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h49; host_mem[1] = 8'h4D; host_mem[2] = 8'h41;
      host_mem[3] = 8'h50; host_mem[4] = 8'h53;
      exp_p[0] = 16'h696D; exp_p[1] = 16'h6170; exp_p[2] = 16'h7300;
      stub_pair   = 1;
      stub_offset = LAT;
      send_host(5, 0, 1'b0, 1'b1);
      wait_result(1);
      total++; if (pairs.size() != 3) begin bad++; $display("FAIL imaps_npairs got %0d want 3", pairs.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < pairs.size()) ? pairs[i] : 16'hxxxx;
         total++; if (got !== exp_p[i]) begin bad++; $display("FAIL imaps_pair%0d got %h want %h", i, got, exp_p[i]); end
      end
      total++; if (res_count != 1) begin bad++; $display("FAIL imaps_nresult got %0d want 1", res_count); end
      total++; if (res_hit !== 1'b1) begin bad++; $display("FAIL imaps_hit got %b want 1", res_hit); end
      total++; if (res_len !== 8'd5) begin bad++; $display("FAIL imaps_len got %0d want 5", res_len); end
      total++; if (res_trunc !== 1'b0) begin bad++; $display("FAIL imaps_trunc got %b want 0", res_trunc); end
      total++; if (res_cyc - last_pair_cyc != LAT + 1) begin bad++; $display("FAIL imaps_latency got %0d want %0d", res_cyc - last_pair_cyc, LAT + 1); end
   endtask

   task automatic test_unaligned_hit();
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h61; host_mem[1] = 8'h62;
      stub_pair   = 0;
      stub_offset = LAT - 1;
      send_host(2, 0, 1'b0, 1'b1);
      wait_result(1);
      got = (pairs.size() > 0) ? pairs[0] : 16'hxxxx;
      total++; if (pairs.size() != 1) begin bad++; $display("FAIL ab_npairs got %0d want 1", pairs.size()); end
      total++; if (got !== 16'h6162) begin bad++; $display("FAIL ab_pair got %h want 6162", got); end
      total++; if (res_hit !== 1'b0) begin bad++; $display("FAIL ab_hit got %b want 0", res_hit); end
      total++; if (res_len !== 8'd2) begin bad++; $display("FAIL ab_len got %0d want 2", res_len); end
   endtask

   task automatic test_case_fold();
      logic [15:0] exp_p [0:2];
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h40; host_mem[1] = 8'h41; host_mem[2] = 8'h5A;
      host_mem[3] = 8'h5B; host_mem[4] = 8'h60; host_mem[5] = 8'h7A;
      exp_p[0] = 16'h4061; exp_p[1] = 16'h7A5B; exp_p[2] = 16'h607A;
      send_host(6, 0, 1'b0, 1'b1);
      wait_result(1);
      for (int i = 0; i < 3; i++) begin
         got = (i < pairs.size()) ? pairs[i] : 16'hxxxx;
         total++; if (got !== exp_p[i]) begin bad++; $display("FAIL fold_pair%0d got %h want %h", i, got, exp_p[i]); end
      end
      total++; if (res_len !== 8'd6 || res_count != 1) begin bad++; $display("FAIL fold_result got len=%0d n=%0d want 6/1", res_len, res_count); end
   endtask

   task automatic test_gaps();
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h6D; host_mem[1] = 8'h61; host_mem[2] = 8'h69; host_mem[3] = 8'h6C;
      send_host(4, 2, 1'b0, 1'b1);
      wait_result(1);
      total++; if (pairs.size() != 2) begin bad++; $display("FAIL gap_npairs got %0d want 2", pairs.size()); end
      got = (pairs.size() > 0) ? pairs[0] : 16'hxxxx;
      total++; if (got !== 16'h6D61) begin bad++; $display("FAIL gap_pair0 got %h want 6d61", got); end
      got = (pairs.size() > 1) ? pairs[1] : 16'hxxxx;
      total++; if (got !== 16'h696C) begin bad++; $display("FAIL gap_pair1 got %h want 696c", got); end
      total++; if (res_len !== 8'd4 || res_trunc !== 1'b0 || res_hit !== 1'b0) begin bad++; $display("FAIL gap_result got len=%0d trunc=%b hit=%b want 4/0/0", res_len, res_trunc, res_hit); end
   endtask

   task automatic test_trunc();
      logic [15:0] got;
      logic [15:0] want;
      logic [7:0]  hi;
      logic [7:0]  lo;
      reset_counters();
      for (int i = 0; i < 300; i++) host_mem[i] = 8'h41 + 8'(i % 26);
      send_host(300, 0, 1'b0, 1'b1);
      wait_result(1);
      total++; if (pairs.size() != 128) begin bad++; $display("FAIL trunc_npairs got %0d want 128", pairs.size()); end
      for (int k = 0; k < 128; k++) begin
         hi   = 8'h61 + 8'((2 * k) % 26);
         lo   = (k < 127) ? 8'h61 + 8'((2 * k + 1) % 26) : 8'h00;
         want = {hi, lo};
         got  = (k < pairs.size()) ? pairs[k] : 16'hxxxx;
         total++; if (got !== want) begin bad++; $display("FAIL trunc_pair%0d got %h want %h", k, got, want); end
      end
      total++; if (res_len !== 8'd255) begin bad++; $display("FAIL trunc_len got %0d want 255", res_len); end
      total++; if (res_trunc !== 1'b1) begin bad++; $display("FAIL trunc_flag got %b want 1", res_trunc); end
      total++; if (stalls != 0) begin bad++; $display("FAIL trunc_stalls got %0d want 0", stalls); end
      total++; if (runs.size() != 1 || runs[0] != LAT + 2) begin bad++; $display("FAIL trunc_ready_low got n=%0d want one run of %0d", runs.size(), LAT + 2); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h65; host_mem[1] = 8'h78; host_mem[2] = 8'h61;
      send_host(3, 0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      total++; if (match_rst !== 1'b1) begin bad++; $display("FAIL mid_match_rst got %b want 1", match_rst); end
      total++; if (sni_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got %b want 0", sni_ready); end
      @(negedge clk);
      @(negedge clk);
      total++; if (match_rst !== 1'b1 || match_valid !== 1'b0) begin bad++; $display("FAIL mid_hold got rst=%b valid=%b want 1/0", match_rst, match_valid); end
      rst = 1'b0;
      #1;
      total++; if (sni_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got %b want 1", sni_ready); end
      repeat (10) @(negedge clk);
      total++; if (res_count != 0) begin bad++; $display("FAIL mid_no_result got %0d want 0", res_count); end
      reset_counters();
      host_mem[0] = 8'h78;
      send_host(1, 0, 1'b0, 1'b1);
      wait_result(1);
      got = (pairs.size() > 0) ? pairs[0] : 16'hxxxx;
      total++; if (pairs.size() != 1 || got !== 16'h7800) begin bad++; $display("FAIL x_pair got n=%0d %h want 1 7800", pairs.size(), got); end
      total++; if (res_len !== 8'd1 || res_count != 1) begin bad++; $display("FAIL x_result got len=%0d n=%0d want 1/1", res_len, res_count); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got;
      reset_counters();
      host_mem[0] = 8'h61; host_mem[1] = 8'h62;
      send_host(2, 0, 1'b1, 1'b1);
      host_mem[0] = 8'h63; host_mem[1] = 8'h64;
      send_host(2, 0, 1'b0, 1'b1);
      wait_result(2);
      total++; if (res_count != 2) begin bad++; $display("FAIL b2b_nresult got %0d want 2", res_count); end
      got = (pairs.size() > 1) ? pairs[1] : 16'hxxxx;
      total++; if (pairs.size() != 2 || pairs[0] !== 16'h6162 || got !== 16'h6364) begin bad++; $display("FAIL b2b_pairs got n=%0d second=%h want 2 6364", pairs.size(), got); end
      total++; if (stalls != LAT + 2) begin bad++; $display("FAIL b2b_stalls got %0d want %0d", stalls, LAT + 2); end
      total++; if (runs.size() != 2 || runs[0] != LAT + 2) begin bad++; $display("FAIL b2b_ready_low got n=%0d want first run %0d", runs.size(), LAT + 2); end
      total++; if (mrst_cycles != 2) begin bad++; $display("FAIL b2b_match_rst got %0d cycles want 2", mrst_cycles); end
      total++; if (res_len !== 8'd2) begin bad++; $display("FAIL b2b_len got %0d want 2", res_len); end
   endtask

   initial begin
      rst       = 1'b1;
      sni_valid = 1'b0;
      sni_data  = 8'h00;
      sni_last  = 1'b0;
      test_reset();
      test_imaps();
      test_unaligned_hit();
      test_case_fold();
      test_gaps();
      test_trunc();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sni_byte_packer.md
# sni_byte_packer

- Stage directly upstream of the 2-bytes-per-cycle SNI matchers (e.g. `imaps_2bytes_percycle`).
- Takes SNI hostname bytes one per cycle from the TLS parser, folds ASCII to lower case, and packs them into 16-bit pairs on the matcher's `valid`/`data` interface.
- Pulses the matcher's reset between hostnames so each hostname is matched from a clean state.
- Collects the matcher's hit output over the hostname and reports one result per hostname.

## Interface
Parameters:
- `MATCH_LATENCY`, 3 — cycles from `o_match_data_valid` to the corresponding `i_imaps_matched` (range 1..7).
- `MAX_SNI_BYTES`, 255 — bytes forwarded per hostname; excess bytes are accepted and dropped.

Ports:
- `i_clk`  in  1 — single clock.
- `i_rst`  in  1 — synchronous, active-high reset.
- `i_sni_valid`  in  1 — input byte valid.
- `i_sni_data`  in  8 — hostname byte.
- `i_sni_last`  in  1 — final byte of the hostname.
- `o_sni_ready`  out  1 — byte accepted when `i_sni_valid & o_sni_ready`.
- `o_match_data_valid`  out  1 — pair valid to the matcher.
- `o_match_data`  out  16 — `[15:8]` is the earlier byte, `[7:0]` the later byte.
- `o_match_rst`  out  1 — matcher reset.
- `i_imaps_matched`  in  1 — matcher hit.
- `o_result_valid`  out  1 — one-cycle result strobe.
- `o_result_hit`  out  1 — a pattern matched within the hostname.
- `o_result_len`  out  8 — number of bytes forwarded (saturates at `MAX_SNI_BYTES`).
- `o_result_trunc`  out  1 — hostname exceeded `MAX_SNI_BYTES`.

## Operation
- FSM states: `IDLE`, `PACK`, `FLUSH`, `CLEAR`.
  - `IDLE` → `PACK` on the first accepted byte.
  - `PACK` → `FLUSH` once the last pair has been emitted.
  - `FLUSH` → `CLEAR` after `MATCH_LATENCY` cycles.
  - `CLEAR` → `IDLE` after 1 cycle.
- `o_sni_ready` is 1 in `IDLE` and `PACK`. It is 0 from the cycle after the last byte is accepted until `CLEAR` has completed.
- Case folding: bytes 0x41–0x5A get +0x20. All other bytes pass unchanged.
- Packing: the first byte of each pair is held in `[15:8]`. The pair is emitted when the second byte arrives.
  - If `i_sni_last` arrives on a high-lane byte, the pair is emitted the next cycle with low lane = 0x00 (pad byte). The pad byte is not counted in `o_result_len`.
- Length: the byte counter is 8 bits. Once it reaches `MAX_SNI_BYTES`, further bytes are dropped and `trunc` is set. A pending odd byte is still flushed with the pad byte when last arrives.
- Hit capture: a `MATCH_LATENCY`-deep shift register records emitted-valid. The sticky hit register ORs in `i_imaps_matched & valid_dly[MATCH_LATENCY-1]`. Matcher output without an aligned valid is ignored.
- `CLEAR` state: `o_result_valid=1` and `o_match_rst=1`. Hit, length, trunc and the pair register are cleared on exit.
- `o_match_rst = i_rst | (state==CLEAR)`.
- Reset mid-hostname: the partial hostname is discarded and no result is emitted.
- Reset values:
  - All outputs 0 except `o_sni_ready` (0 during reset, 1 in the first cycle after reset) and `o_match_rst` (1 during reset).
  - State returns to `IDLE`.

## Timing
- Byte 2k+1 accepted in cycle t → pair on `o_match_data_valid` in t+1 (registered).
- Last pair emitted in cycle T:
  - `FLUSH` spans T+1..T+`MATCH_LATENCY`.
  - `i_imaps_matched` is sampled through T+`MATCH_LATENCY`.
  - `CLEAR` / `o_result_valid` at T+`MATCH_LATENCY`+1.
  - `o_sni_ready`=1 at T+`MATCH_LATENCY`+2.
- Steady-state throughput: 1 byte/cycle in, 1 pair every 2 cycles out.
- The upstream may insert gaps between bytes (`i_sni_valid` low). The pair register holds its contents, and the matcher sees no valid during the gap.
- Simultaneous last byte and truncation: the byte is dropped and the flush proceeds normally.

## Structure
- Shared package `sni_pkg`, containing:
  - state encoding `IDLE/PACK/FLUSH/CLEAR`;
  - `ASCII_UPPER_A`=0x41, `ASCII_UPPER_Z`=0x5A, `ASCII_CASE_OFFSET`=0x20, `SNI_PAD_BYTE`=0x00;
  - `SNI_LEN_W`=8.
- One natural sub-module: `sni_valid_delay`, a parameterised valid shift register reused to align any matcher with its result.

## Test plan
- "IMAPS" (5 bytes, uppercase), matcher stub asserting a hit 3 cycles after pair 2:
  - pairs 0x696D, 0x6170, 0x7300;
  - `o_result_hit`=1, `o_result_len`=5, `o_result_trunc`=0;
  - `o_result_valid` 4 cycles after the 0x7300 pair.
- "ab" with a stub hit arriving with no aligned valid → `o_result_hit`=0, len=2, single pair 0x6162.
- 300-byte hostname → 127 full pairs + 1 padded pair, len=255, trunc=1, `o_sni_ready` low only after last.
- Byte gaps: "mail" with 2 idle cycles between every byte → pairs 0x6D61, 0x696C, result unchanged vs. no-gap case.
- Reset asserted after 3 bytes of "example" → no `o_result_valid`, `o_match_rst`=1 during reset. The next hostname "x" yields pair 0x7800, len=1.
- Back-to-back hostnames with `i_sni_valid` held high → `o_sni_ready` low for exactly `MATCH_LATENCY`+2 cycles, and `o_match_rst` pulses once between them.
